// File: rtl/cdr_lf_pkg.sv
// Shared types, default gains and the saturating adder for the CDR loop filter.
package cdr_lf_pkg;

  typedef logic signed [1:0] vote_t;

  localparam int DEF_CODE_W   = 11;
  localparam int DEF_PHASE_W  = 16;
  localparam int DEF_FREQ_W   = 16;
  localparam int DEF_KP       = 8;
  localparam int DEF_KI       = 3;
  localparam int DEF_FSHIFT   = 7;
  localparam int DEF_DECIM    = 4;
  localparam int DEF_LOCK_WIN = 64;
  localparam int DEF_LOCK_THR = 8;

  // Adds a and b, clamping to the signed range of a w-bit integer (w <= 32).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [33:0] s;
    logic signed [33:0] hi;
    logic signed [33:0] lo;
    s  = 34'(a) + 34'(b);
    hi = (34'sd1 <<< (w - 1)) - 34'sd1;
    lo = -hi - 34'sd1;
    if (s > hi) begin
      sat_add = 32'(hi);
    end else if (s < lo) begin
      sat_add = 32'(lo);
    end else begin
      sat_add = 32'(s);
    end
  endfunction

endpackage

// File: rtl/cdr_lf_vote_acc.sv
// Decimating vote accumulator: sums Up/Dn votes over DECIM enabled cycles and
// emits the sign of the window total as a combinational decision.
module cdr_lf_vote_acc
  import cdr_lf_pkg::*;
#(
  parameter int DECIM = DEF_DECIM
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  up_i,
  input  logic  dn_i,
  input  logic  en_i,
  output vote_t d_o,
  output logic  d_vld_o
);

  localparam int SUM_W = $clog2(DECIM) + 2;
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [SUM_W-1:0] total;
  vote_t                   vote;
  logic                    wrap;

  always_comb begin
    vote = '0;
    if (up_i && !dn_i) begin
      vote = 2'sb01;
    end else if (dn_i && !up_i) begin
      vote = 2'sb11;
    end
    total = sum_q + SUM_W'(vote);
    wrap  = en_i && (cnt_q == LAST);

    cnt_d = cnt_q;
    sum_d = sum_q;
    if (wrap) begin
      cnt_d = '0;
      sum_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
      sum_d = total;
    end

    // The final vote of the window is folded in before taking the sign.
    d_o = '0;
    if (wrap) begin
      if (total[SUM_W-1]) begin
        d_o = 2'sb11;
      end else if (total != '0) begin
        d_o = 2'sb01;
      end
    end
    d_vld_o = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sum_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/cdr_loop_filter.sv
// Second-order bang-bang CDR loop filter: saturating frequency integrator and
// wrapping phase integrator. Optional lock detector under CDR_LF_LOCK_DET_EN.
module cdr_loop_filter
  import cdr_lf_pkg::*;
#(
  parameter int CODE_W   = DEF_CODE_W,
  parameter int PHASE_W  = DEF_PHASE_W,
  parameter int FREQ_W   = DEF_FREQ_W,
  parameter int KP       = DEF_KP,
  parameter int KI       = DEF_KI,
  parameter int FSHIFT   = DEF_FSHIFT,
  parameter int DECIM    = DEF_DECIM,
  parameter int LOCK_WIN = DEF_LOCK_WIN,
  parameter int LOCK_THR = DEF_LOCK_THR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up,
  input  logic                     dn,
  input  logic                     en,
  output logic [CODE_W-1:0]        code,
  output logic                     code_vld,
  output logic signed [FREQ_W-1:0] freq,
  output logic                     locked
);

  localparam int PW2 = PHASE_W + 2;

  vote_t d;
  logic  d_vld;

  cdr_lf_vote_acc #(.DECIM(DECIM)) u_vote_acc (
    .clk     (clk),
    .rst     (rst),
    .up_i    (up),
    .dn_i    (dn),
    .en_i    (en),
    .d_o     (d),
    .d_vld_o (d_vld)
  );

  logic signed [FREQ_W-1:0] freq_q, freq_d, freq_sh;
  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic signed [PW2-1:0]    kp_term, phase_sum;
  logic                     code_vld_q;

  // Phase uses the pre-update freq so a simultaneous saturation cannot leak in.
  always_comb begin
    freq_sh   = freq_q >>> FSHIFT;
    kp_term   = d[1] ? -PW2'(KP) : PW2'(KP);
    phase_sum = $signed({2'b00, phase_q}) + kp_term + PW2'(freq_sh);
    phase_d   = phase_q;
    freq_d    = freq_q;
    if (d_vld && (d != '0)) begin
      phase_d = phase_sum[PHASE_W-1:0];
      freq_d  = FREQ_W'(sat_add(32'(freq_q), d[1] ? -KI : KI, FREQ_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      freq_q     <= '0;
      phase_q    <= '0;
      code_vld_q <= 1'b0;
    end else begin
      freq_q     <= freq_d;
      phase_q    <= phase_d;
      code_vld_q <= d_vld;
    end
  end

  assign code     = phase_q[PHASE_W-1 -: CODE_W];
  assign code_vld = code_vld_q;
  assign freq     = freq_q;

`ifdef CDR_LF_LOCK_DET_EN
  localparam int LC_W  = (LOCK_WIN > 1) ? $clog2(LOCK_WIN) : 1;
  localparam int NET_W = $clog2(LOCK_WIN + 1) + 2;

  logic [LC_W-1:0]         lk_cnt_q, lk_cnt_d;
  logic signed [NET_W-1:0] lk_net_q, lk_net_d, net_tot, net_abs;
  logic                    locked_q, locked_d;

  always_comb begin
    net_tot  = lk_net_q + NET_W'(d);
    net_abs  = net_tot[NET_W-1] ? -net_tot : net_tot;
    lk_cnt_d = lk_cnt_q;
    lk_net_d = lk_net_q;
    locked_d = locked_q;
    if (d_vld) begin
      if (lk_cnt_q == LC_W'(LOCK_WIN - 1)) begin
        locked_d = (net_abs <= NET_W'(LOCK_THR));
        lk_cnt_d = '0;
        lk_net_d = '0;
      end else begin
        lk_cnt_d = lk_cnt_q + 1'b1;
        lk_net_d = net_tot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_cnt_q <= '0;
      lk_net_q <= '0;
      locked_q <= 1'b0;
    end else begin
      lk_cnt_q <= lk_cnt_d;
      lk_net_q <= lk_net_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Self-checking bench for cdr_loop_filter: integer reference model compared
// every cycle, directed scenarios plus randomized Up/Dn/en/rst traffic.
module tb_cdr_loop_filter;

  localparam int CODE_W   = 11;
  localparam int PHASE_W  = 16;
  localparam int FREQ_W   = 16;
  localparam int KP       = 8;
  localparam int KI       = 3;
  localparam int FSHIFT   = 7;
  localparam int DECIM    = 4;
  localparam int LOCK_WIN = 64;
  localparam int LOCK_THR = 8;
  localparam int FMAX     = (1 << (FREQ_W - 1)) - 1;
  localparam int FMIN     = -(1 << (FREQ_W - 1));
  localparam int PMASK    = (1 << PHASE_W) - 1;

  logic              clk = 1'b0;
  logic              rst, up, dn, en;
  logic [CODE_W-1:0] code;
  logic              code_vld;
  logic [FREQ_W-1:0] freq;
  logic              locked;

  always #5 clk = ~clk;

  cdr_loop_filter #(
    .CODE_W(CODE_W), .PHASE_W(PHASE_W), .FREQ_W(FREQ_W), .KP(KP), .KI(KI),
    .FSHIFT(FSHIFT), .DECIM(DECIM), .LOCK_WIN(LOCK_WIN), .LOCK_THR(LOCK_THR)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .dn(dn), .en(en),
    .code(code), .code_vld(code_vld), .freq(freq), .locked(locked)
  );

  int errors = 0;
  int checks = 0;
  int vld_cnt;

  // Reference model state, plain integers.
  int m_votes, m_n, m_freq, m_phase, m_lk_n, m_lk_net;
  bit m_vld, m_locked;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_votes = 0; m_n = 0; m_freq = 0; m_phase = 0;
    m_lk_n = 0; m_lk_net = 0; m_vld = 0; m_locked = 0;
  endtask

  task automatic model_edge(input bit r, input bit u, input bit d_, input bit e);
    int v, dec, nf, a;
    if (r) begin
      model_clear();
      return;
    end
    m_vld = 0;
    if (!e) return;
    v = (u && !d_) ? 1 : ((d_ && !u) ? -1 : 0);
    m_votes += v;
    m_n++;
    if (m_n == DECIM) begin
      dec = (m_votes > 0) ? 1 : ((m_votes < 0) ? -1 : 0);
      m_votes = 0;
      m_n = 0;
      m_vld = 1;
      if (dec != 0) begin
        m_phase = (m_phase + KP * dec + (m_freq >>> FSHIFT)) & PMASK;
        nf = m_freq + KI * dec;
        m_freq = (nf > FMAX) ? FMAX : ((nf < FMIN) ? FMIN : nf);
      end
      m_lk_n++;
      m_lk_net += dec;
      if (m_lk_n == LOCK_WIN) begin
        a = (m_lk_net < 0) ? -m_lk_net : m_lk_net;
        m_locked = (a <= LOCK_THR);
        m_lk_n = 0;
        m_lk_net = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit u, input bit d_, input bit e);
    bit exp_lock;
    rst = r; up = u; dn = d_; en = e;
    @(posedge clk);
    model_edge(r, u, d_, e);
    #1;
`ifdef CDR_LF_LOCK_DET_EN
    exp_lock = m_locked;
`else
    exp_lock = 1'b0;
`endif
    chk("code", longint'(code), longint'(m_phase >> (PHASE_W - CODE_W)));
    chk("code_vld", longint'(code_vld), longint'(m_vld));
    chk("freq", longint'($signed(freq)), longint'(m_freq));
    chk("locked", longint'(locked), longint'(exp_lock));
    if (code_vld) vld_cnt++;
  endtask

  task automatic window(input bit u, input bit d_);
    for (int i = 0; i < DECIM; i++) step(1'b0, u, d_, 1'b1);
  endtask

  initial begin
    model_clear();
    rst = 1'b1; up = 1'b0; dn = 1'b0; en = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_code", longint'(code), 0);
    chk("rst_freq", longint'($signed(freq)), 0);
    chk("rst_vld", longint'(code_vld), 0);
    chk("rst_locked", longint'(locked), 0);

    // Steady up votes: freq 3,6,9,12 and phase 8,16,24,32.
    vld_cnt = 0;
    window(1'b1, 1'b0);
    chk("s1_freq1", longint'($signed(freq)), 3);
    for (int w = 0; w < 3; w++) window(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s1_pulses", vld_cnt, 4);
    chk("s1_freq4", longint'($signed(freq)), 12);
    chk("s1_code4", longint'(code), 1);

    // Balanced votes and all-11 window give d=0.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    vld_cnt = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    window(1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s2_pulses", vld_cnt, 2);
    chk("s2_freq", longint'($signed(freq)), 0);
    chk("s2_code", longint'(code), 0);

    // A single dn window wraps phase below zero.
    window(1'b0, 1'b1);
    chk("s3_freq", longint'($signed(freq)), -3);
    chk("s3_code", longint'(code), 2047);

    // Long run of up windows saturates freq.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 11000; w++) window(1'b1, 1'b0);
    chk("s4_freq_sat", longint'($signed(freq)), 32767);

    // en=0 holds a partial window.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    vld_cnt = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("s5_hold_vld", vld_cnt, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("s5_freq", longint'($signed(freq)), 3);

    // rst mid-window discards the partial window.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("s5_rst_freq", longint'($signed(freq)), 0);
    vld_cnt = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("s5_rst_partial", vld_cnt, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s5_rst_full", vld_cnt, 1);

    // Lock detector: balanced decisions lock, one-sided ones unlock.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < LOCK_WIN / 2; w++) begin
      window(1'b1, 1'b0);
      window(1'b0, 1'b1);
    end
`ifdef CDR_LF_LOCK_DET_EN
    chk("s6_lock", longint'(locked), 1);
`else
    chk("s6_lock", longint'(locked), 0);
`endif
    for (int w = 0; w < LOCK_WIN; w++) window(1'b1, 1'b0);
    chk("s6_unlock", longint'(locked), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
